fp32_mul_arbiter: RTL and testbench

Shares one combinational `fp32_mul` datapath among `NUM_REQ` independent requesters. Each requester uses a valid/ready operand channel. The block grants one requester per cycle in round-robin order and registers the operands. It then returns the product on a single tagged response channel that honours backpressure. The block sits between the FP32 client units and the shared multiplier. It sustains one multiply per cycle with a fixed 2-cycle latency.

---
 rtl/fp32_pkg.sv | 14 +
 rtl/fp32_mul.sv | 77 +++++++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/fp32_mul_arbiter.sv | 106 ++++++++++
 tb/tb_fp32_mul_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the multiplier datapath and its arbiter.
// Provides the word width, the fp32_t word type and a few canonical
// encodings used by the datapath and by clients.
package fp32_pkg;

    localparam int FP32_W = 32;

    typedef logic [FP32_W-1:0] fp32_t;

    localparam fp32_t FP32_ONE  = 32'h3F800000;
    localparam fp32_t FP32_PINF = 32'h7F800000;
    localparam fp32_t FP32_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fp32_mul.sv
// Combinational single-precision multiplier.
//   a, b : FP32 operands
//   y    : FP32 product
// Behaviour:
//   - round to nearest, ties to even
//   - subnormal inputs are treated as signed zero, results below the
//     smallest normal are flushed to signed zero
//   - any NaN input, or Inf times zero, yields the canonical quiet NaN
//   - results beyond the largest finite value become signed infinity
module fp32_mul
    import fp32_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t y
);

    logic               sign;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]        prod;
    logic [22:0]        frac_n;
    logic               guard, sticky, round_up;
    logic [23:0]        frac_r;
    logic signed [10:0] exp_n;
    logic signed [10:0] exp_r;

    always_comb begin
        sign   = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);

        // Product of two 1.23 significands lies in [1, 4): bit 47 tells
        // whether one extra normalisation shift is needed.
        prod  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        exp_n = 11'(ea) + 11'(eb) - 11'sd127;
        if (prod[47]) begin
            frac_n = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_n + 11'sd1;
        end else begin
            frac_n = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end

        round_up = guard && (sticky || frac_n[0]);
        // A carry out of the fraction means the significand rounded up to
        // 2.0; the fraction bits are then all zero, so only the exponent moves.
        frac_r   = {1'b0, frac_n} + {23'd0, round_up};
        exp_r    = exp_n + 11'(frac_r[23]);

        y = {sign, 31'd0};
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            y = FP32_QNAN;
        end else if (a_inf || b_inf) begin
            y = {sign, FP32_PINF[30:0]};
        end else if (a_zero || b_zero) begin
            y = {sign, 31'd0};
        end else if (exp_r >= 11'sd255) begin
            y = {sign, FP32_PINF[30:0]};
        end else if (exp_r <= 11'sd0) begin
            y = {sign, 31'd0};
        end else begin
            y = {sign, exp_r[7:0], frac_r[22:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own last-grant pointer.
//   clk, rst_n : clock and synchronous active-low reset
//   req        : request vector, one bit per requester
//   advance    : the current grant was taken; move the pointer onto it
//   gnt        : one-hot grant (all zero when nothing requests)
//   gnt_idx    : encoded index of the granted requester
//   gnt_any    : some requester is granted
// The search starts one past the last taken grant and wraps, so the most
// recently served requester has the lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    logic [ID_W-1:0] last_gnt;
    logic [ID_W-1:0] cand [NUM_REQ];

    // cand[k] is the requester examined at search position k+1 after the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand[gi] = ID_W'((int'(last_gnt) + gi + 1) % NUM_REQ);
    end

    // Walk from the lowest to the highest priority position; the last hit
    // written is the nearest one after the pointer.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                gnt          = '0;
                gnt[cand[k]] = 1'b1;
                gnt_idx      = cand[k];
                gnt_any      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= ID_W'(NUM_REQ - 1);
        end else if (advance) begin
            last_gnt <= gnt_idx;
        end
    end

endmodule

// File: rtl/fp32_mul_arbiter.sv
// Shares one combinational fp32_mul among NUM_REQ requesters.
//   clk, rst_n  : clock and synchronous active-low reset
//   req_valid   : per-requester operand pair presented
//   req_ready   : per-requester operand pair accepted (at most one bit high)
//   req_a/req_b : per-requester FP32 operands
//   rsp_valid   : response register holds a result
//   rsp_ready   : consumer accepts the response
//   rsp_id      : index of the requester that issued the operands
//   rsp_result  : FP32 product
//   idle        : both pipeline stages empty
// Two register stages (operands, response) give a fixed two-cycle latency
// and one multiply per cycle; a stalled response freezes both stages.
module fp32_mul_arbiter
    import fp32_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0][31:0] req_a,
    input  logic [NUM_REQ-1:0][31:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    idle
);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    logic               s1_valid;
    fp32_t              s1_a;
    fp32_t              s1_b;
    logic [ID_W-1:0]    s1_id;

    logic               s2_load;
    logic               s1_advance;
    logic               s1_load;
    logic               transfer;
    fp32_t              mul_y;

    assign s2_load    = !rsp_valid || rsp_ready;
    assign s1_advance = s1_valid && s2_load;
    // Gated by rst_n so nothing is offered to requesters during reset.
    assign s1_load    = rst_n && (!s1_valid || s1_advance);
    assign req_ready  = s1_load ? gnt : '0;
    assign transfer   = s1_load && gnt_any;
    assign idle       = !s1_valid && !rsp_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (transfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    fp32_mul u_mul (
        .a (s1_a),
        .b (s1_b),
        .y (mul_y)
    );

    // Stage 1: operand register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (s1_load) begin
            s1_valid <= transfer;
            if (transfer) begin
                s1_a  <= req_a[gnt_idx];
                s1_b  <= req_b[gnt_idx];
                s1_id <= gnt_idx;
            end
        end
    end

    // Stage 2: response register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
        end else if (s2_load) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_result <= mul_y;
                rsp_id     <= s1_id;
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Self-checking bench for fp32_mul_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model (round-robin
// search, in-flight count, ordered response queue, arithmetic FP32 product).
module tb_fp32_mul_arbiter;
    import fp32_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][31:0]    req_a;
    logic [N-1:0][31:0]    req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [31:0]           rsp_result;
    logic                  idle;

    always #5 clk = ~clk;

    fp32_mul_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .idle       (idle)
    );

    fp32_t ref_a, ref_b, ref_y;
    fp32_mul u_ref (.a(ref_a), .b(ref_b), .y(ref_y));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   res;
    } exp_t;
    exp_t exp_q[$];

    int           inflight;
    int           rr_ptr;
    logic [N-1:0] acc;
    logic         s_rsp_valid;
    logic [IW-1:0] s_rsp_id;
    logic [31:0]  s_rsp_result;
    logic         s_idle;
    logic [N-1:0] s_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp_v);
        end
    endtask

    // Exact product p = ma*mb scaled by 2^(ea+eb-300); keep 24 significant
    // bits, round to nearest even on the discarded remainder.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, msb, sh, e;
        longint unsigned p, q, rem, half;
        logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 23'd0);
        b_nan  = (eb == 255) && (b[22:0] != 23'd0);
        a_inf  = (ea == 255) && !a_nan;
        b_inf  = (eb == 255) && !b_nan;
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return FP32_QNAN;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        msb = 0;
        for (int i = 0; i < 64; i++) if (p[i]) msb = i;
        sh   = msb - 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            sh = sh + 1;
        end
        e = sh + ea + eb - 150;
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int c;
        logic [31:0] r;
        c = $urandom_range(0, 19);
        r = $urandom;
        if (c < 12) r[30:23] = 8'($urandom_range(64, 190));
        else if (c == 12) r[30:0] = 31'd0;
        else if (c == 13) r[30:0] = 31'h7F800000;
        else if (c == 14) begin r[30:23] = 8'hFF; r[0] = 1'b1; end
        else if (c == 15) r = FP32_ONE;
        return r;
    endfunction

    // Sampled at the falling edge: judges this cycle's handshakes, which
    // complete at the coming rising edge.
    task automatic monitor();
        logic [N-1:0] exp_rdy;
        int w;
        exp_t e;
        s_rsp_valid  = rsp_valid;
        s_rsp_id     = rsp_id;
        s_rsp_result = rsp_result;
        s_idle       = idle;
        s_ready      = req_ready;
        acc          = '0;
        if (!rst_n) begin
            check("ready_in_reset", 32'(req_ready), 0);
            exp_q.delete();
            inflight = 0;
            rr_ptr   = N - 1;
            return;
        end
        exp_rdy = '0;
        if (req_valid != '0 && (inflight < 2 || rsp_ready)) begin
            w = 0;
            for (int k = N; k >= 1; k--) if (req_valid[(rr_ptr + k) % N]) w = (rr_ptr + k) % N;
            exp_rdy[w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("idle", 32'(idle), 32'(inflight == 0));
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", 32'(rsp_valid), 0);
            end else begin
                check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                check("rsp_result", rsp_result, exp_q[0].res);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    inflight--;
                end
            end
        end
        acc = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                e.id  = IW'(i);
                e.res = ref_mul(req_a[i], req_b[i]);
                exp_q.push_back(e);
                rr_ptr = i;
                inflight++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b, input string tag);
        ref_a = a;
        ref_b = b;
        req_valid[id] = 1'b1;
        req_a[id]     = a;
        req_b[id]     = b;
        rsp_ready     = 1'b1;
        tick();
        check({tag, "_accept"}, 32'(s_ready), 32'(1) << id);
        req_valid[id] = 1'b0;
        tick();
        tick();
        check({tag, "_valid"}, 32'(s_rsp_valid), 1);
        check({tag, "_vs_ref"}, s_rsp_result, ref_y);
        check({tag, "_model"}, ref_y, ref_mul(a, b));
        tick();
    endtask

    logic [31:0] bp_a   [3] = '{32'h40000000, 32'h3F800000, 32'h40400000};
    logic [31:0] bp_b   [3] = '{32'h40400000, 32'hC0000000, 32'h40400000};
    logic [31:0] bp_res [3] = '{32'h40C00000, 32'hC0000000, 32'h41100000};
    logic [4:0]  bp_rdy [5] = '{5'd2, 5'd2, 5'd0, 5'd0, 5'd0};

    initial begin
        int nacc;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        ref_a     = '0;
        ref_b     = '0;
        inflight  = 0;
        rr_ptr    = N - 1;
        acc       = '0;
        tick();
        tick();

        // Values after reset
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_last_gnt", 32'(dut.u_arb.last_gnt), N - 1);
        monitor();
        @(posedge clk);
        #1;

        // Round-robin fairness with all requesters valid
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b1;
            req_a[i]     = 32'h40400000;
            req_b[i]     = 32'h3F000000;
        end
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_grant", 32'(s_ready), 32'(1) << (g % N));
            if (g >= 2) check("rr_rsp_id", 32'(s_rsp_id), (g - 2) % N);
        end
        req_valid = '0;
        for (int d = 0; d < 3; d++) begin
            tick();
            if (d < 2) begin
                check("rr_drain_id", 32'(s_rsp_id), (d + 3) % N);
                check("rr_result", s_rsp_result, 32'h3FC00000);
            end else begin
                check("rr_idle", 32'(s_idle), 1);
            end
        end

        // Single request latency
        req_valid[0] = 1'b1;
        req_a[0]     = 32'h3F800000;
        req_b[0]     = 32'h40000000;
        tick();
        check("single_accept", 32'(s_ready), 1);
        req_valid[0] = 1'b0;
        tick();
        check("single_t1_valid", 32'(s_rsp_valid), 0);
        tick();
        check("single_t2_valid", 32'(s_rsp_valid), 1);
        check("single_id", 32'(s_rsp_id), 0);
        check("single_result", s_rsp_result, 32'h40000000);
        tick();
        check("single_idle", 32'(s_idle), 1);

        // Backpressure from requester 1
        rsp_ready    = 1'b0;
        nacc         = 0;
        req_valid[1] = 1'b1;
        req_a[1]     = bp_a[0];
        req_b[1]     = bp_b[0];
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_ready", 32'(s_ready), 32'(bp_rdy[c]));
            if (c >= 2) begin
                check("bp_hold_valid", 32'(s_rsp_valid), 1);
                check("bp_hold_id", 32'(s_rsp_id), 1);
                check("bp_hold_result", s_rsp_result, bp_res[0]);
            end
            if (s_ready[1] && nacc < 2) begin
                nacc++;
                req_a[1] = bp_a[nacc];
                req_b[1] = bp_b[nacc];
            end
        end
        rsp_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            tick();
            if (r == 0) begin
                check("bp_rel_accept", 32'(s_ready), 2);
                req_valid[1] = 1'b0;
            end
            if (r < 3) begin
                check("bp_rel_valid", 32'(s_rsp_valid), 1);
                check("bp_rel_id", 32'(s_rsp_id), 1);
                check("bp_rel_result", s_rsp_result, bp_res[r]);
            end else begin
                check("bp_rel_idle", 32'(s_idle), 1);
            end
        end

        // Special values through requester 2
        run_one(2, 32'h7F800000, 32'h00000000, "inf_x_zero");
        check("nan_class", 32'(ref_y[30:23] == 8'hFF && ref_y[22:0] != 23'd0), 1);
        run_one(2, 32'h4F000000, 32'h4F000000, "big_sq");
        run_one(2, 32'h7F000000, 32'h7F000000, "overflow");
        check("overflow_inf", ref_y, 32'h7F800000);
        run_one(2, 32'h00800000, 32'h00800000, "underflow");
        check("underflow_zero", ref_y, 32'h00000000);
        check("last_gnt_hold", 32'(dut.u_arb.last_gnt), 2);

        // Contention across the wrap point
        req_valid[3] = 1'b1;
        req_a[3]     = rand_fp();
        req_b[3]     = rand_fp();
        req_valid[0] = 1'b1;
        req_a[0]     = rand_fp();
        req_b[0]     = rand_fp();
        tick();
        check("wrap_first", 32'(s_ready), 8);
        req_valid[3] = 1'b0;
        tick();
        check("wrap_second", 32'(s_ready), 1);
        req_valid[0] = 1'b0;
        for (int d = 0; d < 3; d++) tick();
        check("wrap_last_gnt", 32'(dut.u_arb.last_gnt), 0);

        // Reset with both stages full
        rsp_ready    = 1'b0;
        req_valid[1] = 1'b1;
        req_a[1]     = rand_fp();
        req_b[1]     = rand_fp();
        tick();
        req_a[1] = rand_fp();
        req_b[1] = rand_fp();
        tick();
        tick();
        check("full_stall_ready", 32'(s_ready), 0);
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_rsp_valid", 32'(s_rsp_valid), 0);
        check("mid_rst_idle", 32'(s_idle), 1);
        check("mid_rst_last_gnt", 32'(dut.u_arb.last_gnt), N - 1);
        rsp_ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            tick();
            check("mid_rst_no_stale", 32'(s_rsp_valid), 0);
        end

        // Randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req_valid[i] = 1'b1;
                        req_a[i]     = rand_fp();
                        req_b[i]     = rand_fp();
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("drain_empty", 32'(exp_q.size()), 0);
        tick();
        check("final_idle", 32'(s_idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
